round_ctrl: RTL and testbench
=============================

ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 Parameter ROUNDS, default 4, number of count rounds per run; legal range 1..15.
REQ-002 Parameter BASE, default 8'd16, terminal value n for round 0.
REQ-003 Parameter STEP, default 8'd16, increment of n between rounds.
REQ-004 Port mclk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port start  input  1  request a run; sampled only in IDLE.
REQ-007 Port limit  input  1  terminal flag from the downstream up-counter.
REQ-008 Port n  output  8  terminal value driven to the up-counter.
REQ-009 Port sreset  output  1  synchronous clear driven to the up-counter.
REQ-010 Port busy  output  1  high in every state except IDLE.
REQ-011 Port done  output  1  one-cycle pulse when the last round completes.
REQ-012 Port round  output  4  index of the current round, 0-based.
REQ-013 Port err  output  1  one-cycle watchdog-abort pulse.

Function
REQ-014 All outputs SHALL be registered; FSM states SHALL be IDLE, LOAD, RUN, NEXT, DONE.
REQ-015 IDLE: sreset=1, busy=0; start=1 SHALL load round=0, n=BASE and enter LOAD on the next edge.
REQ-016 LOAD: sreset=1 for exactly one cycle, then RUN unconditionally.
REQ-017 RUN: sreset=0; limit=0 SHALL hold RUN; limit=1 SHALL enter DONE if round==ROUNDS-1, else NEXT.
REQ-018 NEXT: round SHALL increment by 1, n SHALL become min(n+STEP, 255) using a 9-bit sum, then LOAD.
REQ-019 DONE: done=1 and sreset=1 for one cycle, then IDLE; round and n SHALL hold their final values until the next start.
REQ-020 start SHALL be ignored while busy=1; a start held high through DONE SHALL begin a new run from IDLE.
REQ-021 Latency: start sampled at edge t gives LOAD at t+1 and RUN at t+2; limit sampled at edge u gives NEXT or DONE at u+1.
REQ-022 Because sreset clears limit before RUN is entered, the first RUN cycle SHALL never see a stale limit.
REQ-023 Each round SHALL be armed by exactly one LOAD cycle; no round SHALL be skipped or repeated.

Reset
REQ-024 reset=1 at any edge SHALL force IDLE, round=0, n=BASE, sreset=1, busy=0, done=0, err=0.
REQ-025 reset SHALL take priority over start, limit and the watchdog, including mid-run.

Configuration
REQ-026 Macro ROUND_CTRL_WATCHDOG_EN SHALL compile in the RUN watchdog.
REQ-027 With the macro, a 10-bit cycle counter SHALL clear on entry to RUN and increment each RUN cycle.
REQ-028 With the macro, when that counter reaches 2*n+8 without limit, the FSM SHALL pulse err for one cycle, drive sreset=1 and return to IDLE.
REQ-029 Without the macro, err SHALL be tied to 0 and RUN SHALL wait indefinitely for limit.

Verification
REQ-030 ROUNDS=2, BASE=3, STEP=2; pulse start; model counter -> n=3 in round 0, n=5 in round 1, one done pulse, sreset high exactly one cycle before each RUN.
REQ-031 BASE=250, STEP=16, ROUNDS=3 -> n sequence 250, 255, 255 (saturation), round 0,1,2.
REQ-032 Assert reset during RUN of round 1 -> next cycle IDLE, round=0, n=BASE, sreset=1, no done.
REQ-033 start held high continuously, ROUNDS=1 -> back-to-back runs with one IDLE cycle between DONE and LOAD; done pulses once per run.
REQ-034 Macro defined, limit tied 0, BASE=4 -> err pulses exactly 16 cycles after RUN entry, then IDLE; macro undefined -> FSM stays in RUN, err=0.

Source files
------------

// File: rtl/round_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : round_ctrl_if
//  Purpose  : Handshake bundle between the round controller and its
//             environment (start request in, up-counter terminal flag in,
//             terminal value / counter clear / status out).
//  Signals  : start  - run request (environment -> controller)
//             limit  - up-counter terminal flag (environment -> controller)
//             n      - 8-bit terminal value for the up-counter
//             sreset - synchronous clear for the up-counter
//             busy   - controller is not idle
//             done   - one-cycle pulse at the end of the last round
//             round  - 4-bit 0-based index of the current round
//             err    - one-cycle watchdog-abort pulse
//  Modports : master - controller side, slave - environment side
//  Revision : 1.0  initial release
// ============================================================================
interface round_ctrl_if;
    logic       start;
    logic       limit;
    logic [7:0] n;
    logic       sreset;
    logic       busy;
    logic       done;
    logic [3:0] round;
    logic       err;

    modport master (
        input  start,
        input  limit,
        output n,
        output sreset,
        output busy,
        output done,
        output round,
        output err
    );

    modport slave (
        output start,
        output limit,
        input  n,
        input  sreset,
        input  busy,
        input  done,
        input  round,
        input  err
    );
endinterface
`default_nettype wire

// File: rtl/round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : round_ctrl
//  Purpose  : Sequences ROUNDS count rounds of a downstream up-counter. Each
//             round the counter is cleared for one LOAD cycle and then runs
//             until it raises limit at terminal value n. n starts at BASE and
//             grows by STEP per round, saturating at 255.
//  Ports    : mclk  - clock, all state changes on its rising edge
//             reset - synchronous active-high reset
//             bus   - round_ctrl_if.master (start, limit, n, sreset, busy,
//                     done, round, err)
//  Options  : ROUND_CTRL_WATCHDOG_EN - when defined, a RUN-state watchdog
//             aborts a round that runs 2*n+8 cycles without limit, pulsing
//             err. When undefined, err is tied low and RUN waits forever.
//  Revision : 1.0  initial release
// ============================================================================
module round_ctrl #(
    parameter int unsigned ROUNDS = 4,       // rounds per run, 1..15
    parameter logic [7:0]  BASE   = 8'd16,   // terminal value of round 0
    parameter logic [7:0]  STEP   = 8'd16    // increment of n per round
) (
    input  logic         mclk,
    input  logic         reset,
    round_ctrl_if.master bus
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t     state;
    logic [3:0] round_q;
    logic [7:0] n_q;
    logic       sreset_q;
    logic       busy_q;
    logic       done_q;

    // Next-round terminal value: 9-bit sum so a carry out saturates to 255.
    logic [8:0] n_sum;
    logic [7:0] n_next;

    assign n_sum  = {1'b0, n_q} + {1'b0, STEP};
    assign n_next = n_sum[8] ? 8'hFF : n_sum[7:0];

`ifdef ROUND_CTRL_WATCHDOG_EN
    // RUN-cycle counter; 2*255+8 = 518 fits in 10 bits.
    logic       err_q;
    logic [9:0] wd_cnt;
    logic [9:0] wd_cnt_inc;
    logic [9:0] wd_limit;
    logic       wd_expire;

    assign wd_cnt_inc = wd_cnt + 10'd1;
    assign wd_limit   = {1'b0, n_q, 1'b0} + 10'd8;
    // Fires on the edge at which the counter would reach 2*n+8.
    assign wd_expire  = (wd_cnt_inc == wd_limit);
`endif

    always_ff @(posedge mclk) begin
        if (reset) begin
            state    <= IDLE;
            round_q  <= 4'd0;
            n_q      <= BASE;
            sreset_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ROUND_CTRL_WATCHDOG_EN
            err_q    <= 1'b0;
            wd_cnt   <= 10'd0;
`endif
        end else begin
            // done and err are single-cycle pulses.
            done_q <= 1'b0;
`ifdef ROUND_CTRL_WATCHDOG_EN
            err_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // round and n keep their final values until a new start.
                    if (bus.start) begin
                        state    <= LOAD;
                        round_q  <= 4'd0;
                        n_q      <= BASE;
                        busy_q   <= 1'b1;
                        sreset_q <= 1'b1;
                    end
                end

                LOAD: begin
                    // The counter was held clear during LOAD, so RUN never
                    // starts with a stale limit.
                    state    <= RUN;
                    sreset_q <= 1'b0;
`ifdef ROUND_CTRL_WATCHDOG_EN
                    wd_cnt   <= 10'd0;
`endif
                end

                RUN: begin
                    if (bus.limit) begin
                        if (round_q == LAST_ROUND) begin
                            state    <= DONE;
                            done_q   <= 1'b1;
                            sreset_q <= 1'b1;
                        end else begin
                            state    <= NEXT;
                        end
                    end
`ifdef ROUND_CTRL_WATCHDOG_EN
                    else if (wd_expire) begin
                        state    <= IDLE;
                        err_q    <= 1'b1;
                        sreset_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end else begin
                        wd_cnt   <= wd_cnt_inc;
                    end
`endif
                end

                NEXT: begin
                    // sreset stays low here so the only clear pulse a later
                    // round sees is its single LOAD cycle.
                    state    <= LOAD;
                    round_q  <= round_q + 4'd1;
                    n_q      <= n_next;
                    sreset_q <= 1'b1;
                end

                DONE: begin
                    state    <= IDLE;
                    busy_q   <= 1'b0;
                    sreset_q <= 1'b1;
                end

                default: begin
                    state    <= IDLE;
                    busy_q   <= 1'b0;
                    sreset_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.n      = n_q;
    assign bus.round  = round_q;
    assign bus.sreset = sreset_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
`ifdef ROUND_CTRL_WATCHDOG_EN
    assign bus.err    = err_q;
`else
    assign bus.err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_round_ctrl
//  Purpose  : Self-checking bench for round_ctrl. Three instances with
//             different ROUNDS/BASE/STEP are compared every cycle against a
//             behavioural model, plus directed scenario checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_round_ctrl;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;
    localparam int P_NEXT = 3;
    localparam int P_DONE = 4;

`ifdef ROUND_CTRL_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    // Per-instance configuration: rounds, base, step.
    int cr[3] = '{2, 3, 1};
    int cb[3] = '{3, 250, 4};
    int cs[3] = '{2, 16, 1};

    logic mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic rst0, rst1, rst2;

    round_ctrl_if if0 ();
    round_ctrl_if if1 ();
    round_ctrl_if if2 ();

    round_ctrl #(.ROUNDS(2), .BASE(8'd3),   .STEP(8'd2))  dut0 (.mclk(mclk), .reset(rst0), .bus(if0));
    round_ctrl #(.ROUNDS(3), .BASE(8'd250), .STEP(8'd16)) dut1 (.mclk(mclk), .reset(rst1), .bus(if1));
    round_ctrl #(.ROUNDS(1), .BASE(8'd4),   .STEP(8'd1))  dut2 (.mclk(mclk), .reset(rst2), .bus(if2));

    int checks;
    int failures;

    // Behavioural model state per instance.
    int   ph[3];
    int   rr[3];
    int   wd[3];
    logic ee[3];

    // Previous-cycle busy/sreset per instance.
    logic pb[3];
    logic ps[3];

    // Up-counter model feeding dut0's limit.
    logic [7:0] cnt0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_n(input int k, input int r);
        int v;
        v = cb[k] + r * cs[k];
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_step(input int k, input logic rst, input logic st, input logic lim);
        int nn;
        nn    = exp_n(k, rr[k]);
        ee[k] = 1'b0;
        if (rst === 1'b1) begin
            ph[k] = P_IDLE;
            rr[k] = 0;
        end else begin
            case (ph[k])
                P_IDLE: if (st === 1'b1) begin ph[k] = P_LOAD; rr[k] = 0; end
                P_LOAD: begin ph[k] = P_RUN; wd[k] = 0; end
                P_RUN: begin
                    if (lim === 1'b1) begin
                        ph[k] = (rr[k] == cr[k] - 1) ? P_DONE : P_NEXT;
                    end else begin
                        wd[k]++;
                        if (WD_EN && wd[k] == 2 * nn + 8) begin
                            ph[k] = P_IDLE;
                            ee[k] = 1'b1;
                        end
                    end
                end
                P_NEXT: begin rr[k]++; ph[k] = P_LOAD; end
                default: ph[k] = P_IDLE;
            endcase
        end
    endtask

    task automatic check_dut(input int k, input logic b, input logic s, input logic d,
                             input logic e, input logic [3:0] rd, input logic [7:0] nv);
        string p;
        p = $sformatf("d%0d", k);
        chk({p, ".busy"},   32'(b),  32'(ph[k] != P_IDLE));
        chk({p, ".sreset"}, 32'(s),  32'(ph[k] == P_IDLE || ph[k] == P_LOAD || ph[k] == P_DONE));
        chk({p, ".done"},   32'(d),  32'(ph[k] == P_DONE));
        chk({p, ".err"},    32'(e),  32'(ee[k]));
        chk({p, ".round"},  32'(rd), 32'(rr[k]));
        chk({p, ".n"},      32'(nv), 32'(exp_n(k, rr[k])));
    endtask

    function automatic logic is_entry(input int k, input logic b, input logic s);
        return (pb[k] === 1'b1) && (ps[k] === 1'b1) && (b === 1'b1) && (s === 1'b0);
    endfunction

    // One clock: update model on the edge, then sample outputs 1 time unit later.
    task automatic tick();
        pb[0] = if0.busy; ps[0] = if0.sreset;
        pb[1] = if1.busy; ps[1] = if1.sreset;
        pb[2] = if2.busy; ps[2] = if2.sreset;
        @(posedge mclk);
        model_step(0, rst0, if0.start, if0.limit);
        model_step(1, rst1, if1.start, if1.limit);
        model_step(2, rst2, if2.start, if2.limit);
        #1;
        cnt0      = (ps[0] === 1'b0) ? cnt0 + 8'd1 : 8'd0;
        if0.limit = (cnt0 == if0.n);
        check_dut(0, if0.busy, if0.sreset, if0.done, if0.err, if0.round, if0.n);
        check_dut(1, if1.busy, if1.sreset, if1.done, if1.err, if1.round, if1.n);
        check_dut(2, if2.busy, if2.sreset, if2.done, if2.err, if2.round, if2.n);
    endtask

    int   dones;
    int   loads;
    int   errs;
    int   wd_cycles;
    logic found;
    logic pd1, pd2;
    int   n_seen[$];
    int   r_seen[$];

    initial begin
        checks   = 0;
        failures = 0;
        for (int k = 0; k < 3; k++) begin
            ph[k] = P_IDLE; rr[k] = 0; wd[k] = 0; ee[k] = 1'b0;
        end
        cnt0 = 8'd0;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        if0.start = 1'b0; if0.limit = 1'b0;
        if1.start = 1'b0; if1.limit = 1'b0;
        if2.start = 1'b0; if2.limit = 1'b0;
        tick();
        tick();

        // Reset state.
        chk("rst.n0",      32'(if0.n), 32'd3);
        chk("rst.n1",      32'(if1.n), 32'd250);
        chk("rst.round1",  32'(if1.round), 32'd0);
        chk("rst.sreset2", 32'(if2.sreset), 32'd1);
        chk("rst.busy0",   32'(if0.busy), 32'd0);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        tick();

        // Two rounds against the counter model: n=3 then n=5, one done.
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        chk("lat.load_busy",   32'(if0.busy), 32'd1);
        chk("lat.load_sreset", 32'(if0.sreset), 32'd1);
        n_seen.delete(); r_seen.delete();
        dones = 0; loads = 1;
        for (int i = 0; i < 60 && if0.busy === 1'b1; i++) begin
            tick();
            if (i == 0) chk("lat.run_sreset", 32'(if0.sreset), 32'd0);
            if (is_entry(0, if0.busy, if0.sreset)) begin
                n_seen.push_back(int'(if0.n));
                r_seen.push_back(int'(if0.round));
            end
            if (if0.busy === 1'b1 && if0.sreset === 1'b1 && if0.done === 1'b0) loads++;
            if (if0.done === 1'b1) dones++;
        end
        chk("two.idle",  32'(if0.busy), 32'd0);
        chk("two.runs",  32'(n_seen.size()), 32'd2);
        chk("two.loads", 32'(loads), 32'd2);
        chk("two.dones", 32'(dones), 32'd1);
        if (n_seen.size() >= 2) begin
            chk("two.n0", 32'(n_seen[0]), 32'd3);
            chk("two.n1", 32'(n_seen[1]), 32'd5);
            chk("two.r0", 32'(r_seen[0]), 32'd0);
            chk("two.r1", 32'(r_seen[1]), 32'd1);
        end
        chk("two.hold_n",     32'(if0.n), 32'd5);
        chk("two.hold_round", 32'(if0.round), 32'd1);

        // Reset in the middle of round 1.
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (is_entry(0, if0.busy, if0.sreset) && if0.round === 4'd1) found = 1'b1;
        end
        chk("mid.reached", 32'(found), 32'd1);
        tick();
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        chk("mid.busy",   32'(if0.busy), 32'd0);
        chk("mid.round",  32'(if0.round), 32'd0);
        chk("mid.n",      32'(if0.n), 32'd3);
        chk("mid.sreset", 32'(if0.sreset), 32'd1);
        chk("mid.done",   32'(if0.done), 32'd0);
        dones = 0;
        repeat (20) begin
            tick();
            if (if0.done === 1'b1) dones++;
        end
        chk("mid.nodone", 32'(dones), 32'd0);

        // Random start/limit/reset on the saturating instance.
        for (int i = 0; i < 400; i++) begin
            if1.start = ($urandom_range(7) == 0);
            if1.limit = ($urandom_range(3) == 0);
            rst1      = ($urandom_range(39) == 0);
            tick();
        end
        rst1 = 1'b0; if1.start = 1'b0; if1.limit = 1'b1;
        for (int i = 0; i < 40 && if1.busy === 1'b1; i++) tick();
        chk("sat.drained", 32'(if1.busy), 32'd0);

        // Directed saturating run: 250, 255, 255.
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        n_seen.delete(); r_seen.delete();
        for (int i = 0; i < 40 && if1.busy === 1'b1; i++) begin
            tick();
            if (is_entry(1, if1.busy, if1.sreset)) begin
                n_seen.push_back(int'(if1.n));
                r_seen.push_back(int'(if1.round));
            end
        end
        chk("sat.runs", 32'(n_seen.size()), 32'd3);
        if (n_seen.size() >= 3) begin
            chk("sat.n0", 32'(n_seen[0]), 32'd250);
            chk("sat.n1", 32'(n_seen[1]), 32'd255);
            chk("sat.n2", 32'(n_seen[2]), 32'd255);
            chk("sat.r2", 32'(r_seen[2]), 32'd2);
        end

        // start held high, ROUNDS=1: back-to-back runs with one IDLE gap.
        if2.start = 1'b1;
        dones = 0; loads = 0; errs = 0; pd1 = 1'b0; pd2 = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if2.limit = ($urandom_range(2) == 0);
            tick();
            if (pd2) chk("b2b.reload", 32'(if2.busy & if2.sreset), 32'd1);
            if (pd1) chk("b2b.gap", 32'(if2.busy), 32'd0);
            pd2 = pd1;
            pd1 = (if2.done === 1'b1);
            if (pb[2] === 1'b0 && if2.busy === 1'b1) loads++;
            if (if2.done === 1'b1) dones++;
            if (if2.err === 1'b1) errs++;
        end
        if2.start = 1'b0; if2.limit = 1'b1;
        for (int i = 0; i < 20 && if2.busy === 1'b1; i++) begin
            tick();
            if (if2.done === 1'b1) dones++;
            if (if2.err === 1'b1) errs++;
        end
        chk("b2b.balance", 32'(dones + errs), 32'(loads));
        chk("b2b.many",    32'(dones > 4), 32'd1);

        // limit tied low: watchdog abort, or wait forever without it.
        if2.limit = 1'b0; if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (is_entry(2, if2.busy, if2.sreset)) found = 1'b1;
        end
        chk("wd.run_entry", 32'(found), 32'd1);
        wd_cycles = 0; found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            wd_cycles++;
            if (if2.err === 1'b1) found = 1'b1;
        end
`ifdef ROUND_CTRL_WATCHDOG_EN
        chk("wd.err",    32'(found), 32'd1);
        chk("wd.delay",  32'(wd_cycles), 32'd16);
        chk("wd.idle",   32'(if2.busy), 32'd0);
        chk("wd.sreset", 32'(if2.sreset), 32'd1);
        tick();
        chk("wd.pulse",  32'(if2.err), 32'd0);
`else
        chk("wd.noerr",  32'(found), 32'd0);
        chk("wd.busy",   32'(if2.busy), 32'd1);
        chk("wd.sreset", 32'(if2.sreset), 32'd0);
`endif
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        chk("wd.reset_busy", 32'(if2.busy), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
